// File: rtl/ext_bus_defs_pkg.sv
// ext_bus_defs: encodings shared by both ends of the external memory bus.
// Contents:
//   - ExternalDrive request codes.
//   - Responder state encoding.
//   - Error word returned for out-of-range reads.
//   - Request-capture struct.
//   - Helper that recognises a legal request code.
package ext_bus_defs;

   localparam logic [2:0] EXT_IDLE  = 3'b000;
   localparam logic [2:0] EXT_READ  = 3'b001;
   localparam logic [2:0] EXT_WRITE = 3'b010;
   localparam logic [2:0] EXT_FETCH = 3'b101;

   localparam logic [31:0] EXT_ERROR_WORD = 32'hDEAD_BEEF;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_WAIT    = 2'd1,
      ST_ACK     = 2'd2,
      ST_RELEASE = 2'd3
   } extState_t;

   // Request latched in IDLE. Reads and fetches behave identically on this
   // side of the bus, so only the write/not-write distinction is kept.
   typedef struct packed {
      logic        isWrite;
      logic        outOfRange;
      logic [31:0] data;
   } extReq_t;

   function automatic logic isLegalDrive(input logic [2:0] drive);
      return (drive == EXT_READ) || (drive == EXT_WRITE) || (drive == EXT_FETCH);
   endfunction

endpackage

// File: rtl/ext_mem_array.sv
// ext_mem_array: single-port 32-bit word RAM.
// Behaviour:
//   - Synchronous write.
//   - Asynchronous read.
//   - Contents are never reset.
// Ports:
//   clk    - write clock
//   we     - write enable
//   addr   - word address (shared by the read and write ports)
//   wrData - write data
//   rdData - combinational read data at addr
module ext_mem_array #(
   parameter int ADDR_W = 10
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] addr,
   input  logic [31:0]       wrData,
   output logic [31:0]       rdData
);

   logic [31:0] mem [2**ADDR_W];

   always_ff @(posedge clk) begin
      if (we) mem[addr] <= wrData;
   end

   assign rdData = mem[addr];

endmodule

// File: rtl/external_memory_responder.sv
// external_memory_responder: memory-side end of the external bus.
// A request is captured in IDLE and held through a programmable wait. The
// responder then acknowledges with a one-cycle ExternalExchangeReady pulse.
// It stays in RELEASE until the controller drops ExternalDrive, so a request
// held continuously executes only once.
// Ports:
//   clk                   - system clock (rising edge)
//   rst                   - synchronous, active-low reset
//   ExternalAddressBus    - word address; only [ADDR_W-1:0] selects a word
//   ExternalDataBus       - write data in; read data out during ACK of a
//                           read or fetch, otherwise high-Z
//   ExternalDrive         - request code: read, write, fetch, or idle
//   ExternalExchangeReady - one-cycle acknowledge
//   Busy                  - high whenever the responder is not in IDLE
//   ExternalBusError      - present only when EXT_MEM_RANGE_CHECK_EN is
//                           defined; flags an out-of-range address,
//                           coincident with Ready
// Build option EXT_MEM_RANGE_CHECK_EN:
//   An address with nonzero bits above ADDR_W still completes the handshake.
//   Its write is dropped, and its read returns the error word.
//   Without the option, those upper address bits are ignored (wrap-around).
module external_memory_responder
   import ext_bus_defs::*;
#(
   parameter int ADDR_W      = 10,
   parameter int WAIT_CYCLES = 3
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] ExternalAddressBus,
   inout  wire  [31:0] ExternalDataBus,
   input  logic [2:0]  ExternalDrive,
   output logic        ExternalExchangeReady,
   output logic        Busy
`ifdef EXT_MEM_RANGE_CHECK_EN
   ,
   output logic        ExternalBusError
`endif
);

   localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);

   extState_t         state;
   logic [3:0]        waitCnt;
   logic [ADDR_W-1:0] reqAddr;
   extReq_t           req;
   logic              driveBus;
   logic              addrOutOfRange;
   logic              memWe;
   logic [31:0]       memRdData;
   logic [31:0]       busWord;

`ifdef EXT_MEM_RANGE_CHECK_EN
   logic busErr;
   assign addrOutOfRange   = |ExternalAddressBus[31:ADDR_W];
   assign ExternalBusError = busErr;
`else
   logic unusedAddrBits;
   assign unusedAddrBits = ^ExternalAddressBus[31:ADDR_W];
   assign addrOutOfRange = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (!rst) begin
         state                 <= ST_IDLE;
         waitCnt               <= '0;
         ExternalExchangeReady <= 1'b0;
         Busy                  <= 1'b0;
         driveBus              <= 1'b0;
`ifdef EXT_MEM_RANGE_CHECK_EN
         busErr                <= 1'b0;
`endif
      end else begin
         // Acknowledge-phase outputs are single-cycle by default.
         ExternalExchangeReady <= 1'b0;
         driveBus              <= 1'b0;
`ifdef EXT_MEM_RANGE_CHECK_EN
         busErr                <= 1'b0;
`endif
         case (state)
            ST_IDLE: begin
               if (isLegalDrive(ExternalDrive)) begin
                  reqAddr        <= ExternalAddressBus[ADDR_W-1:0];
                  req.isWrite    <= (ExternalDrive == EXT_WRITE);
                  req.outOfRange <= addrOutOfRange;
                  req.data       <= ExternalDataBus;
                  waitCnt        <= WAIT_LOAD;
                  Busy           <= 1'b1;
                  if (WAIT_CYCLES == 0) begin
                     state                 <= ST_ACK;
                     ExternalExchangeReady <= 1'b1;
                     driveBus              <= (ExternalDrive != EXT_WRITE);
`ifdef EXT_MEM_RANGE_CHECK_EN
                     busErr                <= addrOutOfRange;
`endif
                  end else begin
                     state <= ST_WAIT;
                  end
               end
            end
            ST_WAIT: begin
               // The counter holds the number of WAIT cycles still to spend,
               // including the current one.
               waitCnt <= waitCnt - 4'd1;
               if (waitCnt == 4'd1) begin
                  state                 <= ST_ACK;
                  ExternalExchangeReady <= 1'b1;
                  driveBus              <= !req.isWrite;
`ifdef EXT_MEM_RANGE_CHECK_EN
                  busErr                <= req.outOfRange;
`endif
               end
            end
            ST_ACK: state <= ST_RELEASE;
            ST_RELEASE: begin
               if (ExternalDrive == EXT_IDLE) begin
                  state <= ST_IDLE;
                  Busy  <= 1'b0;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   // The write lands on the edge that ends ACK. Any later request is
   // captured after that edge, so it already sees the new data.
   assign memWe = (state == ST_ACK) && req.isWrite && !req.outOfRange;

   ext_mem_array #(.ADDR_W(ADDR_W)) uMem (
      .clk   (clk),
      .we    (memWe),
      .addr  (reqAddr),
      .wrData(req.data),
      .rdData(memRdData)
   );

   assign busWord         = req.outOfRange ? EXT_ERROR_WORD : memRdData;
   assign ExternalDataBus = driveBus ? busWord : 'z;

endmodule

// File: tb/tb_external_memory_responder.sv
`timescale 1ns/1ps
module tb_external_memory_responder;

   localparam int ADDR_W = 10;
   localparam int W      = 3;
   localparam int DEPTH  = 1 << ADDR_W;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst = 1'b0;
   logic [2:0]  drv = 3'b000;
   logic [31:0] addr = '0;
   logic [31:0] tbBusVal = '0;
   logic        relNow = 1'b0;
   wire  [31:0] dataBus;
   logic        ready, busy;
`ifdef EXT_MEM_RANGE_CHECK_EN
   logic        busErr;
`endif

   // The bench drives the data bus except around a predicted read/fetch ACK.
   assign dataBus = relNow ? 32'bz : tbBusVal;

   external_memory_responder #(.ADDR_W(ADDR_W), .WAIT_CYCLES(W)) dut (
      .clk                  (clk),
      .rst                  (rst),
      .ExternalAddressBus   (addr),
      .ExternalDataBus      (dataBus),
      .ExternalDrive        (drv),
      .ExternalExchangeReady(ready),
      .Busy                 (busy)
`ifdef EXT_MEM_RANGE_CHECK_EN
      ,
      .ExternalBusError     (busErr)
`endif
   );

   int vectors = 0, miscompares = 0;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // A transaction is described by the edge number on which it was accepted.
   // Ready is seen after edge ackAt = accept + W. The write lands at ackAt+1.
   // The model is idle again at the first edge >= ackAt+2 that sees Drive == 0.
   logic [31:0] mMem [DEPTH];
   bit          mKnown [DEPTH];
   int          edgeNo = 0;
   bit          mActive = 0;
   int          mAckAt = 0;
   bit          mWr = 0, mErr = 0;
   int          mA = 0;
   logic [31:0] mData = '0;
   bit          expReady = 0, expBusy = 0, expRead = 0, expDataKnown = 0;
   logic [31:0] expData = '0;
`ifdef EXT_MEM_RANGE_CHECK_EN
   bit          expErr = 0;
`endif

   function automatic bit legal(input logic [2:0] d);
      return d == 3'b001 || d == 3'b010 || d == 3'b101;
   endfunction

   function automatic bit outOfRange(input logic [31:0] a);
`ifdef EXT_MEM_RANGE_CHECK_EN
      return a[31:ADDR_W] != 0;
`else
      return a[31] & 1'b0;
`endif
   endfunction

   always @(posedge clk) begin
      edgeNo++;
      if (mActive && mWr && !mErr && edgeNo == mAckAt + 1) begin
         mMem[mA]   = mData;
         mKnown[mA] = 1;
      end
      if (!rst) mActive = 0;
      else if (!mActive) begin
         if (legal(drv)) begin
            mActive = 1;
            mAckAt  = edgeNo + W;
            mWr     = (drv == 3'b010);
            mA      = int'(addr[ADDR_W-1:0]);
            mErr    = outOfRange(addr);
            mData   = tbBusVal;
         end
      end else if (edgeNo >= mAckAt + 2 && drv == 3'b000) mActive = 0;
      expBusy      = mActive;
      expReady     = mActive && edgeNo == mAckAt;
      expRead      = expReady && !mWr;
      expDataKnown = mErr || mKnown[mA];
      expData      = mErr ? 32'hDEAD_BEEF : mMem[mA];
`ifdef EXT_MEM_RANGE_CHECK_EN
      expErr       = expReady && mErr;
`endif
   end

   always @(posedge clk) begin
      #1;
      relNow = mActive && !mWr && (edgeNo + 1 == mAckAt || edgeNo == mAckAt);
   end

   // ---------------- per-cycle compare ----------------
   always @(negedge clk) begin
      if (edgeNo > 0) begin
         check("ready", 32'(ready), 32'(expReady));
         check("busy", 32'(busy), 32'(expBusy));
`ifdef EXT_MEM_RANGE_CHECK_EN
         check("busErr", 32'(busErr), 32'(expErr));
`endif
         if (expRead) begin
            if (expDataKnown) check("rdata", dataBus, expData);
         end else if (!relNow) begin
            check("busfree", dataBus, tbBusVal);
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic step(input logic r, input logic [2:0] d, input logic [31:0] a, input logic [31:0] v);
      rst = r; drv = d; addr = a; tbBusVal = v;
      @(posedge clk); #2;
   endtask

   task automatic waitAck(output int lat, output logic [31:0] bus, output bit err);
      lat = 0; bus = '0; err = 0;
      for (int i = 1; i <= 50; i++) begin
         @(negedge clk);
         if (ready) begin
            lat = i;
            bus = dataBus;
`ifdef EXT_MEM_RANGE_CHECK_EN
            err = busErr;
`endif
            break;
         end
      end
      if (lat == 0) begin
         vectors++; miscompares++;
         $display("FAIL ack_timeout: got no Ready, expected one within 50 cycles");
      end
      @(posedge clk); #2;
   endtask

   task automatic doWrite(input logic [31:0] a, input logic [31:0] v);
      int lat; logic [31:0] b; bit e;
      step(1, 3'b010, a, v);
      waitAck(lat, b, e);
      step(1, 3'b000, a, $urandom);
   endtask

   int pool [16];

   initial begin
      int lat, cnt; logic [31:0] b; bit e;
      for (int i = 0; i < 16; i++) pool[i] = (i * 61 + 7) % DEPTH;
      pool[0] = 371; pool[1] = 540; pool[2] = 0;

      // Reset held with a read request pending.
      step(0, 3'b001, 32'd5, $urandom);
      step(0, 3'b001, 32'd5, $urandom);
      check("rst_ready", 32'(ready), 0);
      check("rst_busy", 32'(busy), 0);

      // Preload the address pool.
      for (int i = 0; i < 16; i++) doWrite(pool[i], $urandom);
      doWrite(32'd0, 32'h0BAD_F00D);

      // Write 4467 (wraps to 371), then read it back.
      step(1, 3'b010, 32'd4467, 32'd555);
      waitAck(lat, b, e);
      check("wr_latency", lat, 4);
      step(1, 3'b000, 0, $urandom);
      step(1, 3'b001, 32'd4467, $urandom);
      waitAck(lat, b, e);
      check("rd_latency", lat, 4);
`ifdef EXT_MEM_RANGE_CHECK_EN
      check("rd_4467", b, 32'hDEAD_BEEF);
`else
      check("rd_4467", b, 32'd555);
`endif
      step(1, 3'b000, 0, $urandom);

      // Fetch from a preloaded word; the bus is free the cycle after.
      doWrite(32'd540, 32'd339);
      step(1, 3'b101, 32'd540, $urandom);
      waitAck(lat, b, e);
      check("fetch_data", b, 32'd339);
      check("fetch_release", dataBus, tbBusVal);
      step(1, 3'b000, 0, $urandom);

      // Held write request: exactly one acknowledge.
      cnt = 0;
      for (int i = 0; i < 12; i++) begin
         step(1, 3'b010, pool[5], 32'hC0DE_0005);
         if (ready) cnt++;
      end
      check("held_pulses", cnt, 1);
      check("held_busy", 32'(busy), 1);
      step(1, 3'b000, 0, $urandom);
      check("held_idle", 32'(busy), 0);

      // Reset in WAIT: no acknowledge, target word keeps 339.
      cnt = 0;
      step(1, 3'b010, 32'd540, 32'h1234);   if (ready) cnt++;
      step(1, 3'b010, 32'd540, 32'h1234);   if (ready) cnt++;
      step(0, 3'b001, 32'd540, $urandom);   if (ready) cnt++;
      step(0, 3'b001, 32'd540, $urandom);   if (ready) cnt++;
      step(1, 3'b000, 0, $urandom);         if (ready) cnt++;
      check("rstwait_pulses", cnt, 0);
      step(1, 3'b001, 32'd540, $urandom);
      waitAck(lat, b, e);
      check("rstwait_word", b, 32'd339);
      step(1, 3'b000, 0, $urandom);

`ifdef EXT_MEM_RANGE_CHECK_EN
      step(1, 3'b001, 32'h0001_0000, $urandom);
      waitAck(lat, b, e);
      check("range_rd", b, 32'hDEAD_BEEF);
      check("range_err", 32'(e), 1);
      step(1, 3'b000, 0, $urandom);
      doWrite(32'h0001_0000, 32'hABCD_0123);
      step(1, 3'b001, 32'd0, $urandom);
      waitAck(lat, b, e);
      check("range_wr_dropped", b, 32'h0BAD_F00D);
      check("range_err_clear", 32'(e), 0);
      step(1, 3'b000, 0, $urandom);
`endif

      // Randomized traffic against the model.
      for (int i = 0; i < 3000; i++) begin
         logic r; logic [2:0] d; logic [31:0] a;
         r = !($urandom_range(63) == 0 && !(mActive && edgeNo == mAckAt));
         d = drv;
         if ($urandom_range(1) == 0) begin
            case ($urandom_range(7))
               0, 1: d = 3'b000;
               2: d = 3'b001;
               3: d = 3'b010;
               4: d = 3'b101;
               default: d = 3'($urandom_range(7));
            endcase
         end
         a = 32'(pool[$urandom_range(15)]);
`ifdef EXT_MEM_RANGE_CHECK_EN
         if ($urandom_range(7) == 0) a[31:ADDR_W] = 22'($urandom_range(1, 4000000));
`else
         a[31:ADDR_W] = 22'($urandom);
`endif
         step(r, d, a, $urandom);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
